mci_mcu_sram_arb: RTL



---
 rtl/mci_mcu_sram_arb_pkg.sv | 24 ++
 rtl/mci_mcu_sram_arb_if.sv | 39 +++
 rtl/mci_rr_arb.sv | 30 +++
 rtl/mci_mcu_sram_arb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mci_mcu_sram_arb_pkg.sv
// Shared types for the MCU SRAM arbiter: FSM states, response pipeline record
// and the round-robin pointer wrap helper.
package mci_mcu_sram_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        LOCKED = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             write;
    } rsp_pipe_t;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/mci_mcu_sram_arb_if.sv
// Requester-side bus and SRAM-side port of the MCU SRAM arbiter.
// slave = arbiter, master = requesters plus the SRAM they share.
interface mci_mcu_sram_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32
);
    // Handshake: requester i holds req_* stable while req_valid[i]=1; the transfer
    // happens in the cycle req_valid[i] & req_gnt[i], and rsp_valid[i] follows 1 cycle later.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_error;
    logic                      sram_cs;
    logic                      sram_we;
    logic [ADDR_W-1:0]         sram_addr;
    logic [DATA_W-1:0]         sram_wdata;
    logic [DATA_W-1:0]         sram_rdata;
    logic                      sram_dbl_err;
    logic [NUM_REQ-1:0]        starve_sts;

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_wdata, sram_rdata, sram_dbl_err,
        output req_gnt, rsp_valid, rsp_rdata, rsp_error,
        output sram_cs, sram_we, sram_addr, sram_wdata, starve_sts
    );

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_wdata, sram_rdata, sram_dbl_err,
        input  req_gnt, rsp_valid, rsp_rdata, rsp_error,
        input  sram_cs, sram_we, sram_addr, sram_wdata, starve_sts
    );

endinterface

// File: rtl/mci_rr_arb.sv
// Combinational round-robin picker: grants the valid requester closest to ptr,
// counting upward with wrap-around. Shared by several MCI resources.
module mci_rr_arb #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int best_dist;

    always_comb begin
        best_dist = N;
        idx       = '0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && ((j + N - int'(ptr)) % N) < best_dist) begin
                best_dist = (j + N - int'(ptr)) % N;
                idx       = IW'(j);
            end
        end
        gnt = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = (best_dist < N) && (idx == IW'(j));
        end
    end

endmodule

// File: rtl/mci_mcu_sram_arb.sv
// MCU SRAM arbiter: round-robin with lock, one-cycle routed responses.
// Optional starvation monitor under `MCI_MCU_SRAM_ARB_STARVE_MON_EN.
module mci_mcu_sram_arb
    import mci_mcu_sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                clk,
    input  logic                rst_b,
    mci_mcu_sram_arb_if.slave   bus,
    output arb_state_e          dbg_state
);

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic               gnt_write;
    logic               gnt_lock;
    rsp_pipe_t          pipe;

    mci_rr_arb #(.N(NUM_REQ), .IW(IDX_W)) u_rr_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // While LOCKED only the owner may be granted, and only when it is valid.
    always_comb begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
        if (state == LOCKED) begin
            gnt_idx = owner;
            for (int i = 0; i < NUM_REQ; i++) begin
                gnt[i] = bus.req_valid[i] && (owner == IDX_W'(i));
            end
        end
    end

    assign gnt_any   = |gnt;
    assign gnt_write = |(gnt & bus.req_write);
    assign gnt_lock  = |(gnt & bus.req_lock);

    assign bus.req_gnt = gnt;
    assign bus.sram_cs = gnt_any;
    assign bus.sram_we = gnt_write;

    always_comb begin
        bus.sram_addr  = '0;
        bus.sram_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                bus.sram_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                bus.sram_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.rsp_valid[i] = pipe.valid && (pipe.idx == IDX_W'(i));
        end
    end

    assign bus.rsp_rdata = (pipe.valid && !pipe.write) ? bus.sram_rdata : '0;
    assign bus.rsp_error = pipe.valid && !pipe.write && bus.sram_dbl_err;
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            pipe   <= '0;
        end else begin
            pipe.valid <= gnt_any;
            pipe.idx   <= gnt_idx;
            pipe.write <= gnt_write;
            case (state)
                IDLE, ARB: begin
                    if (gnt_any) begin
                        rr_ptr <= wrap_inc(pick_idx, NUM_REQ);
                        if (gnt_lock) begin
                            state <= LOCKED;
                            owner <= pick_idx;
                        end else begin
                            state <= ARB;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    // The unlocked owner transfer is still granted; it just ends the lock.
                    if (gnt_any && !gnt_lock) begin
                        state  <= ARB;
                        rr_ptr <= wrap_inc(owner, NUM_REQ);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MCI_MCU_SRAM_ARB_STARVE_MON_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]      wait_cnt [NUM_REQ];
    logic [NUM_REQ-1:0] starve_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] <= '0;
            starve_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i]) begin
                    wait_cnt[i] <= '0;
                end else if (bus.req_valid[i] && wait_cnt[i] != CW'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                    if (wait_cnt[i] == CW'(STARVE_LIMIT - 1)) starve_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.starve_sts = starve_q;
`else
    assign bus.starve_sts = '0;
`endif

endmodule
